// File: rtl/alu_pipe.sv
// Handshaked ALU stage: valid/ready in, registered result with back-pressure.
// Ports: clk/rst (sync, active-high), in_* op bundle, out_* result bundle,
// busy. Optional iterative multiplier (opcode 10) enabled by ALU_MUL_EN.
module alu_pipe #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 4,
  parameter int IMM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_rs1_d,
  input  logic [DATA_W-1:0] in_rs2_d,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wr_en,
  output logic              out_rd_en,
  output logic              out_zero,
  output logic              out_carry,
  output logic              out_illegal,
  output logic              busy
);
  localparam int SHW = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_WRI = 4'd6;
  localparam logic [3:0] OP_RD  = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;

  logic              val_q, val_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              rde_q, rde_d;
  logic              zero_q, zero_d;
  logic              cy_q, cy_d;
  logic              ill_q, ill_d;

  logic              out_free;
  logic              accept;
  logic [SHW-1:0]    sh;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W:0]   add_t, sub_t, sll_t, srl_t, sra_t;
  logic [DATA_W-1:0] a_res;
  logic              a_cy, a_wr, a_rde, a_ill;

  assign out_free = !val_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign sh       = in_imm[SHW-1:0];
  assign imm_ext  = DATA_W'(in_imm);

  // Shifts run one bit wider so the last bit shifted out lands in a
  // fixed position; with sh==0 that position holds the padding zero.
  assign add_t = {1'b0, in_rs1_d} + {1'b0, in_rs2_d};
  assign sub_t = {1'b0, in_rs1_d} - {1'b0, in_rs2_d};
  assign sll_t = {1'b0, in_rs1_d} << sh;
  assign srl_t = {in_rs1_d, 1'b0} >> sh;
  assign sra_t = $signed({in_rs1_d, 1'b0}) >>> sh;

  always_comb begin
    a_res = '0;
    a_cy  = 1'b0;
    a_wr  = 1'b1;
    a_rde = 1'b0;
    a_ill = 1'b0;
    unique case (in_opcode)
      OP_ADD: begin a_res = add_t[DATA_W-1:0]; a_cy = add_t[DATA_W]; end
      OP_SUB: begin a_res = sub_t[DATA_W-1:0]; a_cy = sub_t[DATA_W]; end
      OP_AND: a_res = in_rs1_d & in_rs2_d;
      OP_OR:  a_res = in_rs1_d | in_rs2_d;
      OP_XOR: a_res = in_rs1_d ^ in_rs2_d;
      OP_SLL: begin a_res = sll_t[DATA_W-1:0]; a_cy = sll_t[DATA_W]; end
      OP_SRL: begin a_res = srl_t[DATA_W:1]; a_cy = srl_t[0]; end
      OP_SRA: begin a_res = sra_t[DATA_W:1]; a_cy = sra_t[0]; end
      OP_WRI: a_res = imm_ext;
      OP_RD:  begin a_res = in_rs1_d; a_wr = 1'b0; a_rde = 1'b1; end
      default: begin a_wr = 1'b0; a_ill = 1'b1; end
    endcase
  end

  logic              load_alu;
  logic              load_mul;
  logic [DATA_W-1:0] mul_res;
  logic              mul_cy;
  logic [REG_AW-1:0] mul_rd;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t              st_q, st_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] mc_q, mc_d;
  logic [DATA_W-1:0]   mp_q, mp_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [REG_AW-1:0]   mrd_q, mrd_d;
  logic                is_mul;

  assign is_mul   = in_opcode == OP_MUL;
  assign in_ready = (st_q == S_IDLE) && out_free;
  assign busy     = st_q != S_IDLE;
  assign load_alu = accept && !is_mul;
  assign load_mul = (st_q == S_DONE) && out_free;
  assign mul_res  = acc_q[DATA_W-1:0];
  assign mul_cy   = |acc_q[2*DATA_W-1:DATA_W];
  assign mul_rd   = mrd_q;

  always_comb begin
    st_d  = st_q;
    acc_d = acc_q;
    mc_d  = mc_q;
    mp_d  = mp_q;
    cnt_d = cnt_q;
    mrd_d = mrd_q;
    unique case (st_q)
      S_IDLE: begin
        if (accept && is_mul) begin
          st_d  = S_MUL;
          acc_d = '0;
          mc_d  = {{DATA_W{1'b0}}, in_rs1_d};
          mp_d  = in_rs2_d;
          cnt_d = '0;
          mrd_d = in_rd;
        end
      end
      S_MUL: begin
        if (mp_q[0]) acc_d = acc_q + mc_q;
        mc_d  = mc_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(DATA_W - 1)) st_d = S_DONE;
      end
      S_DONE: begin
        if (out_free) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= S_IDLE;
      acc_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
      cnt_q <= '0;
      mrd_q <= '0;
    end else begin
      st_q  <= st_d;
      acc_q <= acc_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
      cnt_q <= cnt_d;
      mrd_q <= mrd_d;
    end
  end
`else
  assign in_ready = out_free;
  assign busy     = 1'b0;
  assign load_alu = accept;
  assign load_mul = 1'b0;
  assign mul_res  = '0;
  assign mul_cy   = 1'b0;
  assign mul_rd   = '0;
`endif

  always_comb begin
    val_d  = val_q;
    res_d  = res_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    rde_d  = rde_q;
    zero_d = zero_q;
    cy_d   = cy_q;
    ill_d  = ill_q;
    if (load_alu) begin
      val_d  = 1'b1;
      res_d  = a_res;
      rd_d   = in_rd;
      wr_d   = a_wr;
      rde_d  = a_rde;
      zero_d = a_res == '0;
      cy_d   = a_cy;
      ill_d  = a_ill;
    end else if (load_mul) begin
      val_d  = 1'b1;
      res_d  = mul_res;
      rd_d   = mul_rd;
      wr_d   = 1'b1;
      rde_d  = 1'b0;
      zero_d = mul_res == '0;
      cy_d   = mul_cy;
      ill_d  = 1'b0;
    end else if (out_ready) begin
      val_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= 1'b0;
      res_q  <= '0;
      rd_q   <= '0;
      wr_q   <= 1'b0;
      rde_q  <= 1'b0;
      zero_q <= 1'b0;
      cy_q   <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      val_q  <= val_d;
      res_q  <= res_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      rde_q  <= rde_d;
      zero_q <= zero_d;
      cy_q   <= cy_d;
      ill_q  <= ill_d;
    end
  end

  assign out_valid   = val_q;
  assign out_result  = res_q;
  assign out_rd      = rd_q;
  assign out_wr_en   = wr_q;
  assign out_rd_en   = rde_q;
  assign out_zero    = zero_q;
  assign out_carry   = cy_q;
  assign out_illegal = ill_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (DATA_W=8).
// Inputs change on negedge; outputs sampled on negedge.
module tb_alu_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [3:0] in_rd;
  logic [7:0] in_rs1_d;
  logic [7:0] in_rs2_d;
  logic [7:0] in_imm;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [3:0] out_rd;
  logic       out_wr_en;
  logic       out_rd_en;
  logic       out_zero;
  logic       out_carry;
  logic       out_illegal;
  logic       busy;

  int checks = 0;
  int failures = 0;

  alu_pipe #(.DATA_W(8), .REG_AW(4), .IMM_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd),
    .in_rs1_d(in_rs1_d), .in_rs2_d(in_rs2_d), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_wr_en(out_wr_en), .out_rd_en(out_rd_en),
    .out_zero(out_zero), .out_carry(out_carry),
    .out_illegal(out_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] rd,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] imm);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_rs1_d  = a;
    in_rs2_d  = b;
    in_imm    = imm;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic flags(input string tag, input logic [7:0] res,
                       input logic cy, input logic wr,
                       input logic rde, input logic ill);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, 32'(out_result), 32'(res));
    chk({tag, "_carry"}, 32'(out_carry), 32'(cy));
    chk({tag, "_zero"}, 32'(out_zero), 32'(res == 8'h00));
    chk({tag, "_wr"}, 32'(out_wr_en), 32'(wr));
    chk({tag, "_rde"}, 32'(out_rd_en), 32'(rde));
    chk({tag, "_ill"}, 32'(out_illegal), 32'(ill));
  endtask

  int nbusy;
  int seen;

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    drive(4'd0, 4'd0, 8'h00, 8'h00, 8'h00);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(out_result), 32'd0);
    chk("rst_wr", 32'(out_wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    cyc();
    drive(4'd0, 4'd3, 8'hF0, 8'h20, 8'h00);
    cyc();
    in_valid = 1'b0;
    flags("add", 8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("add_rd", 32'(out_rd), 32'd3);

    drive(4'd1, 4'd1, 8'h05, 8'h05, 8'h00);
    cyc();
    flags("sub", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(4'd9, 4'd2, 8'h81, 8'h00, 8'h01);
    cyc();
    in_valid = 1'b0;
    flags("sra", 8'hC0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sra_rd", 32'(out_rd), 32'd2);

    drive(4'd0, 4'd5, 8'h01, 8'h02, 8'h00);
    cyc();
    out_ready = 1'b0;
    drive(4'd8, 4'd6, 8'hF0, 8'h0F, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      cyc();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_res", 32'(out_result), 32'h03);
      chk("bp_hold_rd", 32'(out_rd), 32'd5);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    flags("xor", 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("xor_rd", 32'(out_rd), 32'd6);

    drive(4'd7, 4'd7, 8'hA5, 8'h00, 8'h00);
    cyc();
    flags("rd", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(4'd12, 4'd1, 8'h33, 8'h44, 8'h55);
    cyc();
    flags("op12", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    drive(4'd6, 4'd4, 8'h00, 8'h00, 8'h7E);
    cyc();
    flags("wri", 8'h7E, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(4'd4, 4'd4, 8'h3C, 8'h00, 8'h00);
    cyc();
    flags("sll0", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(4'd4, 4'd4, 8'h81, 8'h00, 8'h01);
    cyc();
    flags("sll1", 8'h02, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(4'd5, 4'd4, 8'h03, 8'h00, 8'h01);
    cyc();
    flags("srl1", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(4'd5, 4'd4, 8'h80, 8'h00, 8'h0F);
    cyc();
    flags("srl7", 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(4'd1, 4'd4, 8'h02, 8'h05, 8'h00);
    cyc();
    flags("sub_borrow", 8'hFD, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(4'd2, 4'd4, 8'hCC, 8'hAA, 8'h00);
    cyc();
    flags("and", 8'h88, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(4'd3, 4'd4, 8'hC0, 8'h0A, 8'h00);
    cyc();
    in_valid = 1'b0;
    flags("or", 8'hCA, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("drain_valid", 32'(out_valid), 32'd0);

`ifdef ALU_MUL_EN
    drive(4'd10, 4'd9, 8'h10, 8'h11, 8'h00);
    cyc();
    in_valid = 1'b0;
    nbusy = 0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (out_valid) seen = 1;
      else begin
        if (busy) nbusy++;
        cyc();
      end
    end
    chk("mul_seen", 32'(seen), 32'd1);
    chk("mul_busy_cycles", 32'(nbusy), 32'd9);
    flags("mul", 8'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mul_rd", 32'(out_rd), 32'd9);
    chk("mul_busy_after", 32'(busy), 32'd0);

    drive(4'd10, 4'd9, 8'h10, 8'h11, 8'h00);
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("mul_abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      if (out_valid) seen = 1;
      cyc();
    end
    chk("mul_abort_no_out", 32'(seen), 32'd0);
    chk("mul_abort_busy", 32'(busy), 32'd0);
`else
    drive(4'd10, 4'd9, 8'h10, 8'h11, 8'h00);
    cyc();
    in_valid = 1'b0;
    flags("op10", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("op10_busy", 32'(busy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
